// File: rtl/baud_pkg.sv
// Shared constants and helpers for the UART baud-rate generator.
// Exports default widths/OSR and div_from_rate() to derive divisors.
package baud_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OSR_DEF    = 16;

    // Returns {div_int, div_frac} for a sample rate of baud*osr.
    // Result is rounded to the nearest 1/2^FRAC_W of a cycle.
    function automatic logic [DIV_W_DEF+FRAC_W_DEF-1:0] div_from_rate(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned osr
    );
        longint unsigned denom;
        longint unsigned scaled;
        denom  = baud * osr;
        scaled = ((clk_hz << FRAC_W_DEF) + (denom >> 1)) / denom;
        return scaled[DIV_W_DEF+FRAC_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/baud_rate_gen_if.sv
// Control/tick bundle between a UART and its baud-rate generator.
// master: drives en/load/divisors; slave: returns ticks, index, active.
interface baud_rate_gen_if
    import baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR    = OSR_DEF,
    parameter int OSR_W  = $clog2(OSR)
) ();

    logic              en;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              sample_tick;
    logic              bit_tick;
    logic [OSR_W-1:0]  sample_idx;
    logic              active;

    modport master (
        output en, load, div_int, div_frac,
        input  sample_tick, bit_tick, sample_idx, active
    );

    modport slave (
        input  en, load, div_int, div_frac,
        output sample_tick, bit_tick, sample_idx, active
    );

endinterface

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: adds frac on each step, carry -> extra.
// Ports: clk, reset, clr (restart), step (sample tick), frac in, extra out.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              extra
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, frac};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (step) begin
            acc   <= sum[FRAC_W-1:0];
            extra <= sum[FRAC_W];
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// Fractional baud-rate generator: sample_tick every div_int(+frac) cycles,
// bit_tick every OSR samples. Ports: clk, reset, bus (baud_rate_gen_if.slave).
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR    = OSR_DEF,
    parameter int OSR_W  = $clog2(OSR)
) (
    input logic            clk,
    input logic            reset,
    baud_rate_gen_if.slave bus
);

    localparam logic [DIV_W:0]   CNT_ONE = (DIV_W+1)'(1);
    localparam logic [OSR_W-1:0] IDX_ONE = OSR_W'(1);
    localparam logic [OSR_W-1:0] IDX_MAX = OSR_W'(OSR - 1);

    logic [DIV_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [DIV_W:0]    cnt;
    logic [DIV_W:0]    len_m1;
    logic [OSR_W-1:0]  idx;
    logic              extra;
    logic              active;
    logic              last;
    logic              run;
    logic              tick;

    assign active = |div_int_q;

    // One bit wider than div_int so div_int=max plus extra cannot wrap.
    assign len_m1 = {1'b0, div_int_q}
                  + {{DIV_W{1'b0}}, extra}
                  - CNT_ONE;
    assign last   = (cnt == len_m1);

    // load wins over en, so the load cycle never ticks.
    assign run  = bus.en & ~bus.load & active;
    assign tick = run & last;

    assign bus.sample_tick = tick;
    assign bus.bit_tick    = tick & (idx == IDX_MAX);
    assign bus.sample_idx  = idx;
    assign bus.active      = active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_int_q  <= '0;
            div_frac_q <= '0;
            cnt        <= '0;
            idx        <= '0;
        end else if (bus.load) begin
            div_int_q  <= bus.div_int;
            div_frac_q <= bus.div_frac;
            cnt        <= '0;
            idx        <= '0;
        end else if (run) begin
            if (last) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + IDX_ONE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    baud_frac_acc #(
        .FRAC_W(FRAC_W)
    ) u_frac_acc (
        .clk  (clk),
        .reset(reset),
        .clr  (bus.load),
        .step (tick),
        .frac (div_frac_q),
        .extra(extra)
    );

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen.
// Drives the interface one cycle at a time and checks hand-computed ticks.
module tb_baud_rate_gen;
    import baud_pkg::*;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
    localparam int OSR_W  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    baud_rate_gen_if #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .OSR_W(OSR_W)
    ) bus ();

    baud_rate_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .OSR_W(OSR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic             s_st;
    logic             s_bt;
    logic             s_act;
    logic [OSR_W-1:0] s_idx;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_st  = bus.sample_tick;
        s_bt  = bus.bit_tick;
        s_act = bus.active;
        s_idx = bus.sample_idx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int di, input int df);
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.load     = 1'b1;
        cyc();
        chk("load_no_tick", longint'(s_st), 0);
        bus.load = 1'b0;
    endtask

    initial begin
        int bad;
        int nst;
        int nbt;
        int bt_at;
        int k;
        int t[$];

        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.div_int  = '0;
        bus.div_frac = '0;

        chk("rate_115200", longint'(div_from_rate(50_000_000, 115200, 16)), 434);
        chk("rate_9600", longint'(div_from_rate(16_000_000, 9600, 16)), 1667);

        // Reset state, then 100 cycles enabled with no load.
        cyc();
        cyc();
        chk("rst_active", longint'(s_act), 0);
        chk("rst_tick", longint'(s_st), 0);
        reset  = 1'b0;
        bus.en = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (s_st || s_bt || s_act || (s_idx != 0)) bad++;
        end
        chk("idle_no_load", bad, 0);

        // div_int=3: ticks on cycles 3,6,9..; bit_tick at 48.
        do_load(3, 0);
        bad = 0;
        nbt = 0;
        bt_at = -1;
        for (int c = 1; c <= 49; c++) begin
            cyc();
            if (s_st != ((c % 3) == 0)) bad++;
            if (c == 4) chk("idx_after_1", longint'(s_idx), 1);
            if (s_bt) begin
                nbt++;
                bt_at = c;
                chk("idx_at_bit", longint'(s_idx), 15);
            end
            if (c == 49) chk("idx_wrap", longint'(s_idx), 0);
        end
        chk("div3_pos", bad, 0);
        chk("div3_nbt", nbt, 1);
        chk("div3_bt_at", bt_at, 48);

        // div 3 + 8/16: periods 3,3,4,3,4..; 32 periods = 112 cycles.
        do_load(3, 8);
        for (int c = 1; c <= 300 && t.size() < 33; c++) begin
            cyc();
            if (s_st) t.push_back(c);
        end
        chk("frac_count", t.size(), 33);
        if (t.size() == 33) begin
            chk("frac_p1", t[0], 3);
            chk("frac_p2", t[1] - t[0], 3);
            chk("frac_p3", t[2] - t[1], 4);
            chk("frac_p4", t[3] - t[2], 3);
            chk("frac_p5", t[4] - t[3], 4);
            chk("frac_32p", t[32] - t[0], 112);
        end

        // div 5 with en dropped for 7 cycles at cnt=2.
        do_load(5, 0);
        k = 0;
        do begin cyc(); k++; end while (!s_st && k < 20);
        chk("en_first", k, 5);
        cyc();
        cyc();
        bus.en = 1'b0;
        nst = 0;
        for (int c = 0; c < 7; c++) begin
            cyc();
            if (s_st) nst++;
        end
        chk("en_low_ticks", nst, 0);
        bus.en = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (!s_st && k < 20);
        chk("en_resume", k, 3);
        k = 0;
        do begin cyc(); k++; end while (!s_st && k < 20);
        chk("en_period", k, 5);

        // Mid-period reload: div 10, reload div 2 at cnt=4.
        do_load(10, 0);
        for (int c = 0; c < 4; c++) cyc();
        do_load(2, 0);
        cyc();
        chk("reload_c1", longint'(s_st), 0);
        cyc();
        chk("reload_c2", longint'(s_st), 1);
        chk("reload_idx", longint'(s_idx), 0);

        // div_int=0 stays inactive regardless of div_frac.
        do_load(0, 5);
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            cyc();
            if (s_st || s_bt || s_act || (s_idx != 0)) bad++;
        end
        chk("div0_idle", bad, 0);

        // div_int=1: tick every cycle, bit_tick every 16.
        do_load(1, 0);
        nst = 0;
        nbt = 0;
        bt_at = -1;
        for (int c = 1; c <= 32; c++) begin
            cyc();
            if (s_st) nst++;
            if (s_bt) begin
                nbt++;
                if (bt_at < 0) bt_at = c;
            end
        end
        chk("div1_nst", nst, 32);
        chk("div1_nbt", nbt, 2);
        chk("div1_bt_at", bt_at, 16);

        // Load while a tick would otherwise fire is still silent.
        do_load(1, 0);
        cyc();
        chk("div1_resume", longint'(s_st), 1);

        // Async reset mid-cycle drops outputs immediately.
        @(negedge clk);
        #2;
        chk("pre_rst_tick", longint'(bus.sample_tick), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_tick", longint'(bus.sample_tick), 0);
        chk("async_rst_active", longint'(bus.active), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("post_rst_active", longint'(s_act), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
- Runtime-programmable fractional baud-rate generator for the UART path.
- Produces a single-cycle oversampling tick (sample_tick) and a bit-rate tick (bit_tick, every OSR sample ticks).
- Integer and fractional divisors are loaded at run time, so standard baud rates come out accurately from any system clock.
- Serves UART RX (sample_tick, sample_idx) and UART TX (bit_tick).

Parameters:
- DIV_W, 16, width of the integer divisor and the cycle counter.
- FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W.
- OSR, 16, sample ticks per bit tick; must be >= 2.
- OSR_W, $clog2(OSR), width of sample_idx.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  count enable; when low, all state holds and no ticks are asserted.
- load  in  1  single-cycle pulse; latches div_int/div_frac into shadow registers and restarts the generator.
- div_int  in  DIV_W  integer cycles per sample period; sampled only when load=1.
- div_frac  in  FRAC_W  fractional cycles per sample period; sampled only when load=1.
- sample_tick  out  1  one-cycle pulse at the end of each sample period.
- bit_tick  out  1  one-cycle pulse, coincident with every OSR-th sample_tick.
- sample_idx  out  OSR_W  index of the current sample period within the bit, 0..OSR-1.
- active  out  1  high when the shadow div_int is non-zero, i.e. the generator is producing ticks.

Behaviour:
- Reset: shadow div_int=0 and div_frac=0, cnt=0, acc=0, extra=0, sample_idx=0. All outputs are 0, so the generator is inactive until the first load.
- Load (priority over en):
  - On the clk edge with load=1: shadow <- inputs; cnt, acc, extra and sample_idx all cleared.
  - No tick is asserted in the load cycle.
  - A load arriving mid-period discards the partial period.
- Period length: len = shadow_div_int + extra, where extra is 0 or 1.
- Cycle counter: cnt counts 0..len-1 on enabled cycles and wraps to 0.
- sample_tick is combinational from registers: sample_tick = en & active & (cnt == len-1).
- On each sample_tick edge:
  - {carry, acc} <= acc + shadow_div_frac, computed FRAC_W+1 bits wide.
  - extra <= carry, so the next period is one cycle longer on carry.
  - sample_idx <= (sample_idx == OSR-1) ? 0 : sample_idx + 1.
- bit_tick = sample_tick & (sample_idx == OSR-1).
- Latency: after a load with div_int=N and extra=0, the first sample_tick occurs on the N-th enabled cycle following the load edge.
- Average sample period = div_int + div_frac/2^FRAC_W cycles, exactly, over 2^FRAC_W periods.
- div_int == 0: active=0, no ticks; counters hold at 0 and ignore div_frac.
- div_int == 1, div_frac == 0: sample_tick is high on every enabled cycle.
- en low mid-period: cnt, acc and sample_idx freeze; counting resumes on the same cycle count when en returns high. Ticks are masked while en is low.
- cnt is DIV_W+1 bits wide internally so that len = 2^DIV_W-1+1 does not overflow.
- Async reset mid-period takes effect immediately. Outputs drop the same instant, with no glitch on release.
- load and en both high: load wins; en is ignored for that cycle.

Decomposition:
- Package baud_pkg:
  - Default constants DIV_W_DEF, FRAC_W_DEF, OSR_DEF.
  - A function div_from_rate(clk_hz, baud, osr) that returns {div_int, div_frac} for elaboration-time constants and bench use.
- One natural sub-module, baud_frac_acc:
  - FRAC_W accumulator with carry.
  - Input: step enable (sample_tick), clear (load).
  - Output: extra.
  - Keeps the fractional logic separately testable.
- The cycle counter and sample_idx counter stay in the top level.

Test Plan:
- reset held, then released with no load -> sample_tick=bit_tick=active=0, sample_idx=0 for 100 cycles.
- load div_int=3, div_frac=0, OSR=16, en=1 -> sample_tick on cycles 3, 6, 9, ... after load; bit_tick on cycle 48; sample_idx wraps 15->0 at that tick.
- load div_int=3, div_frac=8 (FRAC_W=4) -> sample period lengths 3,3,4,3,4,3,4...; 32 consecutive periods total exactly 112 cycles.
- div_int=5, toggle en low for 7 cycles at cnt=2 -> no ticks while en low; next tick exactly 3 enabled cycles after en returns, with the period length preserved.
- mid-period load div_int=2 at cnt=4 of a div_int=10 config -> no tick in the load cycle; next tick 2 cycles later; sample_idx restarts at 0.
- load div_int=0 -> active=0 and no ticks for 1000 cycles; a subsequent load div_int=1, div_frac=0 -> sample_tick high every cycle, bit_tick every 16 cycles.
